// File: rtl/hilo_muldiv.sv
// hilo_muldiv
// Iterative multiply/divide engine owning the HI/LO register pair.
// A multiply is a shift-add over WIDTH cycles; a divide is restoring division
// over WIDTH cycles. A final FIX cycle applies the sign correction and writes
// HI/LO. Start to result is WIDTH+1 edges.
//
// Ports:
//   clk, reset           : clock and synchronous active-high reset
//   start, op_div, sign  : launch request (IDLE only), 1 = divide, 1 = signed
//   A, B                 : multiplicand/dividend, multiplier/divisor
//   mthi, mtlo, wdata    : direct HI/LO writes (IDLE only, start has priority)
//   busy                 : operation in flight (combinational from state)
//   done                 : one-cycle pulse after HI/LO take a result
//   div_by_zero          : last divide had B = 0; held until next start/reset
//   outHI, outLO         : HI and LO registers
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic             sign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] outHI,
  output logic [WIDTH-1:0] outLO
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic                 op_div_q, op_div_d;
  logic                 prod_neg_q, prod_neg_d;   // product / quotient sign
  logic                 rem_neg_q, rem_neg_d;     // remainder follows dividend
  logic                 b_zero_q, b_zero_d;
  logic [WIDTH-1:0]     orig_a_q, orig_a_d;       // raw A for divide-by-zero HI
  // Multiply: running product. Divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;         // shifted multiplicand
  logic [WIDTH-1:0]     mplier_q, mplier_d;       // multiplier, or divisor
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;

  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [WIDTH:0]       trial;
  logic [2*WIDTH-1:0]   acc_neg;
  logic [WIDTH-1:0]     quo, rem;

  assign a_abs = (sign && A[WIDTH-1]) ? -A : A;
  assign b_abs = (sign && B[WIDTH-1]) ? -B : B;

  // Trial subtraction on the left-shifted remainder (top WIDTH+1 bits of acc).
  // Bit WIDTH set means the difference went negative, so restore.
  assign trial   = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mplier_q};
  assign acc_neg = -acc_q;
  assign quo     = acc_q[WIDTH-1:0];
  assign rem     = acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_div_d   = op_div_q;
    prod_neg_d = prod_neg_q;
    rem_neg_d  = rem_neg_q;
    b_zero_d   = b_zero_q;
    orig_a_d   = orig_a_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = CALC;
          cnt_d      = '0;
          op_div_d   = op_div;
          prod_neg_d = sign & (A[WIDTH-1] ^ B[WIDTH-1]);
          rem_neg_d  = sign & A[WIDTH-1];
          b_zero_d   = (B == '0);
          orig_a_d   = A;
          acc_d      = op_div ? {{WIDTH{1'b0}}, a_abs} : '0;
          mcand_d    = {{WIDTH{1'b0}}, a_abs};
          mplier_d   = b_abs;
          dbz_d      = 1'b0;
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end

      CALC: begin
        if (op_div_q) begin
          if (trial[WIDTH]) begin
            acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
          end else begin
            acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(WIDTH - 1)) state_d = FIX;
      end

      FIX: begin
        if (op_div_q) begin
          if (b_zero_q) begin
            lo_d = '1;
            hi_d = orig_a_q;
          end else begin
            lo_d = prod_neg_q ? -quo : quo;
            hi_d = rem_neg_q ? -rem : rem;
          end
        end else begin
          {hi_d, lo_d} = prod_neg_q ? acc_neg : acc_q;
        end
        dbz_d   = op_div_q & b_zero_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_div_q   <= 1'b0;
      prod_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      b_zero_q   <= 1'b0;
      orig_a_q   <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_div_q   <= op_div_d;
      prod_neg_q <= prod_neg_d;
      rem_neg_q  <= rem_neg_d;
      b_zero_q   <= b_zero_d;
      orig_a_q   <= orig_a_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign outHI       = hi_q;
  assign outLO       = lo_q;

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Iterative multiply/divide engine that owns the HI/LO register pair of the datapath. The ALU's single-cycle path hands off operands; this block runs a 33-cycle shift-add multiply or restoring divide and writes the 64-bit result into HI/LO. It uses a start/busy/done handshake so the control unit can stall dependent MFHI/MFLO reads, and it supports direct MTHI/MTLO writes.

## Interface
Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request a new operation; sampled only in IDLE.
- op_div  in  1  0 = multiply, 1 = divide.
- sign  in  1  0 = unsigned, 1 = two's-complement signed.
- A  in  WIDTH  multiplicand / dividend.
- B  in  WIDTH  multiplier / divisor.
- mthi  in  1  write wdata to HI; IDLE only.
- mtlo  in  1  write wdata to LO; IDLE only.
- wdata  in  WIDTH  data for mthi/mtlo.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse in the cycle after HI/LO take a result.
- div_by_zero  out  1  valid with done; high when a divide had B = 0.
- outHI  out  WIDTH  HI register.
- outLO  out  WIDTH  LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, start=1: latch op_div and sign. Latch |A| and |B| when sign=1, raw A and B otherwise. Record the result signs: the product/quotient sign is A[msb]^B[msb], and the remainder takes the sign of A. Clear the 6-bit iteration counter, then go to CALC.
- CALC: one iteration per cycle, 32 cycles in total.
  - Multiply: a 64-bit accumulator shifts and adds the multiplicand when the current multiplier bit is 1.
  - Divide: restoring division. Shift the remainder and quotient left, trial-subtract the divisor, and keep the difference when it is non-negative.
  - After the 32nd iteration, go to FIX.
- FIX: apply the sign correction, write HI/LO, set done=1, go to IDLE.
- Multiply result: {HI,LO} = the 64-bit product, negated when sign=1 and the operand signs differ.
- Divide result: LO = quotient, HI = remainder.
  - Signed quotients truncate toward zero.
  - The remainder has the sign of the dividend.
- Signed overflow: -2^31 / -1 gives LO=32'h80000000, HI=0, div_by_zero=0.
- Divide by zero: full 33-cycle latency is kept. LO=32'hFFFFFFFF, HI=A as originally presented (not its magnitude), div_by_zero=1.
- mthi/mtlo in IDLE: write wdata to HI/LO at the edge. If both are asserted, both registers are written.
- start together with mthi/mtlo in IDLE: start wins and the moves are dropped.
- Outside IDLE: start, mthi and mtlo are ignored. A, B, op_div and sign may change freely after the start edge.

## Timing
- Reset (synchronous) forces:
  - state=IDLE, counter=0;
  - outHI=0, outLO=0;
  - busy=0, done=0, div_by_zero=0.
- Reset mid-operation aborts the operation with the same values; no done is produced.
- Start accepted at edge k:
  - busy=1 from after edge k through edge k+33.
  - HI/LO take the result at edge k+33.
  - done=1 for exactly the cycle after edge k+33; busy=0 in that cycle.
- Back-to-back: start may be asserted in the done cycle and is accepted at that edge (edge k+34). Peak throughput is one operation per 34 cycles.
- outHI/outLO hold their previous value throughout CALC; intermediate values never appear on them.
- div_by_zero holds until the next accepted start or reset.
- mthi/mtlo latency: one edge.
- busy is combinational from state (state != IDLE). All other outputs are registered.

## Test plan
- Reset, then multiply with sign=0, A=32'hFFFFFFFF, B=2: done 34 cycles after start, outHI=1, outLO=32'hFFFFFFFE, busy high for exactly 33 cycles.
- Signed multiply, A=-7, B=3: outHI=32'hFFFFFFFF, outLO=32'hFFFFFFEB. Then signed divide, A=-7, B=2: LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1).
- Divide by zero with sign=0, A=100, B=0: LO=32'hFFFFFFFF, HI=100, div_by_zero=1. Then signed -2^31 / -1: LO=32'h80000000, HI=0, div_by_zero=0.
- mthi=1, mtlo=1, wdata=32'h1234 in IDLE: both registers read 32'h1234 after one edge. Then mthi while busy: HI unchanged until the result lands.
- Assert reset at CALC cycle 10 of a multiply: next cycle busy=0, done=0, outHI=outLO=0. A start on the following edge completes normally.
- Assert start in the done cycle: the second result lands exactly 34 cycles after the first. A/B toggled during CALC do not affect either result.
